// File: rtl/perf_pkg.sv
// Shared types for the pipeline performance monitor.
// Provides the FSM state encoding and the default counter width.
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter
  import perf_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_perf_monitor.sv
// Cycle/stall/flush/retire event monitor for the 5-stage CPU.
// Ends the run after MAX_CYCLES counted cycles; supports snapshots.
module pipe_perf_monitor
  import perf_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int MAX_CYCLES = 30
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             retire_i,
  input  logic             clear_i,
  input  logic             snap_i,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic [CNT_W-1:0] snap_cycle_o,
  output logic [CNT_W-1:0] snap_stall_o,
  output logic [CNT_W-1:0] snap_flush_o,
  output logic [CNT_W-1:0] snap_retire_o,
  output logic             snap_valid_o,
  output logic             running_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_CYCLES - 1);

  state_e state;
  logic   count_en;
  logic   stall_ev;

  // IDLE and RUN both count; the IDLE edge is the first cycle
  assign count_en = start_i && (state != DONE) && !clear_i;
  // a stall under a flush is a flush only
  assign stall_ev = stall_i && !flush_i;

  sat_counter #(.W(CNT_W)) u_cycle (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (clear_i),
    .inc   (count_en),
    .count (cycle_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_stall (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (clear_i),
    .inc   (count_en && stall_ev),
    .count (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (clear_i),
    .inc   (count_en && flush_i),
    .count (flush_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_retire (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (clear_i),
    .inc   (count_en && retire_i),
    .count (retire_cnt_o)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      running_o <= 1'b0;
      done_o    <= 1'b0;
    end else if (clear_i) begin
      state     <= IDLE;
      running_o <= 1'b0;
      done_o    <= 1'b0;
    end else if (count_en) begin
      if (cycle_cnt_o == LAST) begin
        state     <= DONE;
        running_o <= 1'b0;
        done_o    <= 1'b1;
      end else begin
        state     <= RUN;
        running_o <= 1'b1;
        done_o    <= 1'b0;
      end
    end
  end

  // capture uses pre-edge values, so it is unaffected by clear
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      snap_cycle_o  <= '0;
      snap_stall_o  <= '0;
      snap_flush_o  <= '0;
      snap_retire_o <= '0;
      snap_valid_o  <= 1'b0;
    end else begin
      snap_valid_o <= snap_i;
      if (snap_i) begin
        snap_cycle_o  <= cycle_cnt_o;
        snap_stall_o  <= stall_cnt_o;
        snap_flush_o  <= flush_cnt_o;
        snap_retire_o <= retire_cnt_o;
      end
    end
  end

endmodule
